y_sram_arbiter: RTL and testbench

Registered, parametrised arbiter that gives NUM_CH requesters shared access to the Y SRAM read/write port, replacing the static enable-based steering of the Y bus. It sits between the Y compute/write datapaths and the Y SRAM. It adds request/grant handshaking, round-robin or fixed-priority selection, bounded hold time with optional lock, and a one-cycle registered bus stage.

---
 rtl/y_sram_arbiter_if.sv | 47 ++++
 rtl/y_sram_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_y_sram_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/y_sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// y_sram_arbiter_if
// Bundles the per-channel request/bus signals and the arbitrated Y SRAM port.
//
// Requester side (driven by the Y compute/write datapaths):
//   in_req, in_lock, in_we            [NUM_CH]         request, lock, write enable
//   in_readAddr1/2, in_writeAddr      [NUM_CH*ADDR_W]  channel i at [i*ADDR_W +: ADDR_W]
//   in_writeData                      [NUM_CH*DATA_W]  channel i at [i*DATA_W +: DATA_W]
// Arbiter side (driven by y_sram_arbiter, all registered):
//   op_grant [NUM_CH] one-hot or zero, op_busy,
//   op_yReadAddress1/2, op_yWriteAddress [ADDR_W], op_yWriteEnable, op_writeData [DATA_W]
//
// Modports: master = requester view, slave = arbiter view.
// ---------------------------------------------------------------------------
interface y_sram_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 256
);
    logic [NUM_CH-1:0]        in_req;
    logic [NUM_CH-1:0]        in_lock;
    logic [NUM_CH*ADDR_W-1:0] in_readAddr1;
    logic [NUM_CH*ADDR_W-1:0] in_readAddr2;
    logic [NUM_CH-1:0]        in_we;
    logic [NUM_CH*ADDR_W-1:0] in_writeAddr;
    logic [NUM_CH*DATA_W-1:0] in_writeData;

    logic [NUM_CH-1:0]        op_grant;
    logic                     op_busy;
    logic [ADDR_W-1:0]        op_yReadAddress1;
    logic [ADDR_W-1:0]        op_yReadAddress2;
    logic [ADDR_W-1:0]        op_yWriteAddress;
    logic                     op_yWriteEnable;
    logic [DATA_W-1:0]        op_writeData;

    modport master (
        output in_req, in_lock, in_readAddr1, in_readAddr2, in_we, in_writeAddr, in_writeData,
        input  op_grant, op_busy, op_yReadAddress1, op_yReadAddress2, op_yWriteAddress,
               op_yWriteEnable, op_writeData
    );

    modport slave (
        input  in_req, in_lock, in_readAddr1, in_readAddr2, in_we, in_writeAddr, in_writeData,
        output op_grant, op_busy, op_yReadAddress1, op_yReadAddress2, op_yWriteAddress,
               op_yWriteEnable, op_writeData
    );
endinterface

// File: rtl/y_sram_arbiter.sv
// ---------------------------------------------------------------------------
// y_sram_arbiter
// Registered arbiter giving NUM_CH requesters shared access to the Y SRAM
// read/write port. Round-robin or fixed-priority selection, bounded hold time
// with owner lock, and a one-cycle registered bus stage.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    y_sram_arbiter_if.slave (requests in, registered SRAM port out)
//
// Parameters:
//   NUM_CH    number of channels (2..8)
//   ADDR_W    SRAM address width
//   DATA_W    SRAM write-data width
//   RR_MODE   1 = round-robin, 0 = fixed priority (channel 0 highest)
//   MAX_HOLD  grant cycles before preemption when others wait; 0 = unlimited
//   IDLE_ADDR address driven while nobody owns the bus
// ---------------------------------------------------------------------------
module y_sram_arbiter #(
    parameter int                NUM_CH    = 2,
    parameter int                ADDR_W    = 11,
    parameter int                DATA_W    = 256,
    parameter int                RR_MODE   = 1,
    parameter int                MAX_HOLD  = 16,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = '1
) (
    input logic             clk,
    input logic             reset,
    y_sram_arbiter_if.slave bus
);
    localparam int IDX_W  = $clog2(NUM_CH);
    // A zero-width counter is illegal, so unlimited hold keeps a 1-bit stub.
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } state_t;

    // Returns the first set bit of mask searching upward from start, wrapping.
    function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_CH-1:0] mask,
                                                     input logic [IDX_W-1:0]  start);
        logic [IDX_W-1:0] win;
        logic             found;
        int               idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(start) + k) % NUM_CH;
            if (!found && mask[idx]) begin
                win   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [ADDR_W-1:0] rd_addr1_q, rd_addr1_d;
    logic [ADDR_W-1:0] rd_addr2_q, rd_addr2_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic [IDX_W-1:0]  search_start;
    logic [NUM_CH-1:0] others_req;
    logic [IDX_W-1:0]  win;
    logic              preempt;

    // Arbitration: decides next owner from the requests sampled this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        hold_d   = hold_q;
        rr_ptr_d = rr_ptr_q;

        search_start = (RR_MODE != 0) ? rr_ptr_q : '0;
        others_req   = bus.in_req & ~grant_q;
        preempt      = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && (|others_req)
                       && !bus.in_lock[owner_q];
        win          = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (|bus.in_req) begin
                    win = pick_winner(bus.in_req, search_start);
                    state_d = ST_OWN;
                end
            end
            ST_OWN: begin
                if (!bus.in_req[owner_q] || preempt) begin
                    // Owner excluded, so release or preemption hands over directly.
                    if (|others_req) begin
                        win = pick_winner(others_req, search_start);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (MAX_HOLD != 0 && hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new grant is issued whenever the search ran and found a winner.
        if ((state_q == ST_IDLE && |bus.in_req) ||
            (state_q == ST_OWN && (!bus.in_req[owner_q] || preempt) && |others_req)) begin
            grant_d      = '0;
            grant_d[win] = 1'b1;
            owner_d      = win;
            hold_d       = HOLD_W'(1);
            if (RR_MODE != 0) begin
                rr_ptr_d = IDX_W'((int'(win) + 1) % NUM_CH);
            end
        end else if (state_d == ST_IDLE) begin
            grant_d = '0;
            hold_d  = '0;
        end
    end

    // Bus stage: registers the inputs of whichever channel holds the grant now.
    always_comb begin
        rd_addr1_d = IDLE_ADDR;
        rd_addr2_d = IDLE_ADDR;
        wr_addr_d  = IDLE_ADDR;
        wr_en_d    = 1'b0;
        wr_data_d  = '0;
        if (state_q == ST_OWN) begin
            rd_addr1_d = bus.in_readAddr1[int'(owner_q)*ADDR_W +: ADDR_W];
            rd_addr2_d = bus.in_readAddr2[int'(owner_q)*ADDR_W +: ADDR_W];
            wr_addr_d  = bus.in_writeAddr[int'(owner_q)*ADDR_W +: ADDR_W];
            wr_en_d    = bus.in_we[owner_q] & grant_q[owner_q];
            wr_data_d  = bus.in_writeData[int'(owner_q)*DATA_W +: DATA_W];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            hold_q     <= '0;
            rr_ptr_q   <= '0;
            rd_addr1_q <= IDLE_ADDR;
            rd_addr2_q <= IDLE_ADDR;
            wr_addr_q  <= IDLE_ADDR;
            wr_en_q    <= 1'b0;
            // NOTE: the wide data register is reset deliberately so no stale beat is visible.
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            hold_q     <= hold_d;
            rr_ptr_q   <= rr_ptr_d;
            rd_addr1_q <= rd_addr1_d;
            rd_addr2_q <= rd_addr2_d;
            wr_addr_q  <= wr_addr_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign bus.op_grant         = grant_q;
    assign bus.op_busy          = |grant_q;
    assign bus.op_yReadAddress1 = rd_addr1_q;
    assign bus.op_yReadAddress2 = rd_addr2_q;
    assign bus.op_yWriteAddress = wr_addr_q;
    assign bus.op_yWriteEnable  = wr_en_q;
    assign bus.op_writeData     = wr_data_q;
endmodule

// File: tb/tb_y_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_y_sram_arbiter
// Directed bench for y_sram_arbiter. Three instances:
//   u_a: 2 channels, round-robin, MAX_HOLD=4 (single request, preemption,
//        lock, write isolation, async reset)
//   u_b: 4 channels, round-robin (fairness rotation)
//   u_c: 4 channels, fixed priority
// Expected values are queued when stimulus is driven and popped when the
// corresponding DUT output is sampled (1 ns after the rising edge).
// ---------------------------------------------------------------------------
module tb_y_sram_arbiter;
    logic clk;
    logic reset;

    y_sram_arbiter_if #(.NUM_CH(2), .ADDR_W(11), .DATA_W(256)) if_a ();
    y_sram_arbiter_if #(.NUM_CH(4), .ADDR_W(11), .DATA_W(32))  if_b ();
    y_sram_arbiter_if #(.NUM_CH(4), .ADDR_W(11), .DATA_W(32))  if_c ();

    y_sram_arbiter #(.NUM_CH(2), .ADDR_W(11), .DATA_W(256), .RR_MODE(1), .MAX_HOLD(4))
        u_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    y_sram_arbiter #(.NUM_CH(4), .ADDR_W(11), .DATA_W(32), .RR_MODE(1), .MAX_HOLD(16))
        u_b (.clk(clk), .reset(reset), .bus(if_b.slave));
    y_sram_arbiter #(.NUM_CH(4), .ADDR_W(11), .DATA_W(32), .RR_MODE(0), .MAX_HOLD(16))
        u_c (.clk(clk), .reset(reset), .bus(if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [255:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       n_cmp = 0;
    int       n_err = 0;

    task automatic sb_push(input string tag, input logic [255:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic check(input logic [255:0] obs);
        sb_item_t it;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: observed %0h required an expected entry", obs);
        end else begin
            it = sb_q.pop_front();
            assert (obs === it.exp)
            else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_a.in_req = '0; if_a.in_lock = '0; if_a.in_we = '0;
        if_a.in_readAddr1 = '0; if_a.in_readAddr2 = '0;
        if_a.in_writeAddr = '0; if_a.in_writeData = '0;
        if_b.in_req = '0; if_b.in_lock = '0; if_b.in_we = '0;
        if_b.in_readAddr1 = '0; if_b.in_readAddr2 = '0;
        if_b.in_writeAddr = '0; if_b.in_writeData = '0;
        if_c.in_req = '0; if_c.in_lock = '0; if_c.in_we = '0;
        if_c.in_readAddr1 = '0; if_c.in_readAddr2 = '0;
        if_c.in_writeAddr = '0; if_c.in_writeData = '0;
    endtask

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();

        // ---------------- reset state ----------------
        sb_push("rst_grant", 256'h0);     check(256'(if_a.op_grant));
        sb_push("rst_busy", 256'h0);      check(256'(if_a.op_busy));
        sb_push("rst_waddr", 256'h7FF);   check(256'(if_a.op_yWriteAddress));
        sb_push("rst_raddr1", 256'h7FF);  check(256'(if_a.op_yReadAddress1));
        sb_push("rst_we", 256'h0);        check(256'(if_a.op_yWriteEnable));
        sb_push("rst_wdata", 256'h0);     check(if_a.op_writeData);
        reset = 1'b0;
        tick();

        // ---------------- single request on ch1 ----------------
        if_a.in_req[1] = 1'b1;
        if_a.in_we[1] = 1'b1;
        if_a.in_writeAddr[11 +: 11] = 11'h010;
        if_a.in_readAddr1[11 +: 11] = 11'h123;
        if_a.in_readAddr2[11 +: 11] = 11'h456;
        if_a.in_writeData[256 +: 256] = 256'hAB;
        sb_push("single_grant", 256'h2);
        sb_push("single_busy", 256'h1);
        sb_push("single_we_before_grant", 256'h0);
        sb_push("single_waddr_before_grant", 256'h7FF);
        sb_push("single_waddr", 256'h010);
        sb_push("single_we", 256'h1);
        sb_push("single_wdata", 256'hAB);
        sb_push("single_raddr1", 256'h123);
        sb_push("single_raddr2", 256'h456);
        tick();
        check(256'(if_a.op_grant));
        check(256'(if_a.op_busy));
        check(256'(if_a.op_yWriteEnable));
        check(256'(if_a.op_yWriteAddress));
        tick();
        check(256'(if_a.op_yWriteAddress));
        check(256'(if_a.op_yWriteEnable));
        check(if_a.op_writeData);
        check(256'(if_a.op_yReadAddress1));
        check(256'(if_a.op_yReadAddress2));
        // Release: the beat driven in the release cycle still drains.
        if_a.in_req[1] = 1'b0;
        if_a.in_writeAddr[11 +: 11] = 11'h011;
        sb_push("release_grant", 256'h0);
        sb_push("release_drain_waddr", 256'h011);
        sb_push("release_drain_we", 256'h1);
        tick();
        check(256'(if_a.op_grant));
        check(256'(if_a.op_yWriteAddress));
        check(256'(if_a.op_yWriteEnable));
        if_a.in_we[1] = 1'b0;
        sb_push("idle_waddr", 256'h7FF);
        sb_push("idle_we", 256'h0);
        sb_push("idle_wdata", 256'h0);
        tick();
        check(256'(if_a.op_yWriteAddress));
        check(256'(if_a.op_yWriteEnable));
        check(if_a.op_writeData);

        // ---------------- preemption after MAX_HOLD=4 ----------------
        if_a.in_req[0] = 1'b1;
        sb_push("preempt_hold1", 256'h1);
        tick();
        check(256'(if_a.op_grant));
        if_a.in_req[1] = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            sb_push($sformatf("preempt_hold%0d", i), 256'h1);
            tick();
            check(256'(if_a.op_grant));
        end
        sb_push("preempt_switch", 256'h2);
        tick();
        check(256'(if_a.op_grant));
        if_a.in_req = '0;
        sb_push("preempt_idle", 256'h0);
        tick();
        check(256'(if_a.op_grant));

        // ---------------- lock holds the grant for 20 cycles ----------------
        if_a.in_req[0] = 1'b1;
        if_a.in_lock[0] = 1'b1;
        sb_push("lock_cycle1", 256'h1);
        tick();
        check(256'(if_a.op_grant));
        if_a.in_req[1] = 1'b1;
        for (int i = 2; i <= 20; i++) begin
            sb_push($sformatf("lock_cycle%0d", i), 256'h1);
            tick();
            check(256'(if_a.op_grant));
        end
        if_a.in_req[0] = 1'b0;
        sb_push("lock_release_to_ch1", 256'h2);
        tick();
        check(256'(if_a.op_grant));
        if_a.in_req = '0;
        if_a.in_lock = '0;
        sb_push("lock_idle", 256'h0);
        tick();
        check(256'(if_a.op_grant));

        // ---------------- write isolation ----------------
        if_a.in_req[0] = 1'b1;
        if_a.in_we[0] = 1'b0;
        if_a.in_writeAddr[0 +: 11] = 11'h100;
        if_a.in_we[1] = 1'b1;
        if_a.in_writeAddr[11 +: 11] = 11'h055;
        sb_push("iso_grant", 256'h1);
        sb_push("iso_we_idle", 256'h0);
        sb_push("iso_waddr_idle", 256'h7FF);
        tick();
        check(256'(if_a.op_grant));
        check(256'(if_a.op_yWriteEnable));
        check(256'(if_a.op_yWriteAddress));
        for (int i = 0; i < 3; i++) begin
            sb_push($sformatf("iso_we_%0d", i), 256'h0);
            sb_push($sformatf("iso_waddr_%0d", i), 256'h100);
            tick();
            check(256'(if_a.op_yWriteEnable));
            check(256'(if_a.op_yWriteAddress));
        end
        if_a.in_req[0] = 1'b0;
        sb_push("iso_drain_waddr", 256'h100);
        sb_push("iso_drain_we", 256'h0);
        tick();
        check(256'(if_a.op_yWriteAddress));
        check(256'(if_a.op_yWriteEnable));
        sb_push("iso_after_waddr", 256'h7FF);
        sb_push("iso_after_we", 256'h0);
        tick();
        check(256'(if_a.op_yWriteAddress));
        check(256'(if_a.op_yWriteEnable));
        if_a.in_we = '0;

        // ---------------- round-robin fairness on 4 channels ----------------
        for (int i = 0; i < 4; i++) if_b.in_writeAddr[i*11 +: 11] = 11'(11'h100 + i);
        if_b.in_req = 4'b1111;
        sb_push("rr_grant0", 256'h1);
        tick();
        check(256'(if_b.op_grant));
        if_b.in_req[0] = 1'b0;
        sb_push("rr_grant1", 256'h2);
        sb_push("rr_beat0", 256'h100);
        tick();
        check(256'(if_b.op_grant));
        check(256'(if_b.op_yWriteAddress));
        if_b.in_req[1] = 1'b0;
        if_b.in_req[0] = 1'b1;
        sb_push("rr_grant2", 256'h4);
        sb_push("rr_beat1", 256'h101);
        tick();
        check(256'(if_b.op_grant));
        check(256'(if_b.op_yWriteAddress));
        if_b.in_req[2] = 1'b0;
        sb_push("rr_grant3", 256'h8);
        sb_push("rr_beat2", 256'h102);
        tick();
        check(256'(if_b.op_grant));
        check(256'(if_b.op_yWriteAddress));
        if_b.in_req[3] = 1'b0;
        sb_push("rr_grant0_again", 256'h1);
        sb_push("rr_beat3", 256'h103);
        tick();
        check(256'(if_b.op_grant));
        check(256'(if_b.op_yWriteAddress));
        if_b.in_req = '0;
        sb_push("rr_idle", 256'h0);
        tick();
        check(256'(if_b.op_grant));

        // ---------------- fixed priority on 4 channels ----------------
        if_c.in_req = 4'b0101;
        sb_push("fixed_ch0_first", 256'h1);
        tick();
        check(256'(if_c.op_grant));
        sb_push("fixed_ch0_held", 256'h1);
        tick();
        check(256'(if_c.op_grant));
        if_c.in_req[0] = 1'b0;
        sb_push("fixed_ch2_next", 256'h4);
        tick();
        check(256'(if_c.op_grant));
        // ch1 and ch3 wait as ch2 drops: lowest index wins regardless of history.
        if_c.in_req = 4'b1010;
        sb_push("fixed_lowest_index", 256'h2);
        tick();
        check(256'(if_c.op_grant));
        if_c.in_req = '0;
        sb_push("fixed_idle", 256'h0);
        tick();
        check(256'(if_c.op_grant));

        // ---------------- async reset mid write burst ----------------
        if_a.in_req[1] = 1'b1;
        if_a.in_we[1] = 1'b1;
        if_a.in_writeAddr[11 +: 11] = 11'h020;
        if_a.in_writeData[256 +: 256] = 256'h5A5A;
        sb_push("burst_grant", 256'h2);
        tick();
        check(256'(if_a.op_grant));
        sb_push("burst_we", 256'h1);
        sb_push("burst_waddr", 256'h020);
        tick();
        check(256'(if_a.op_yWriteEnable));
        check(256'(if_a.op_yWriteAddress));
        #2;
        reset = 1'b1;
        #1;
        sb_push("arst_grant", 256'h0);
        sb_push("arst_busy", 256'h0);
        sb_push("arst_we", 256'h0);
        sb_push("arst_waddr", 256'h7FF);
        sb_push("arst_raddr2", 256'h7FF);
        sb_push("arst_wdata", 256'h0);
        check(256'(if_a.op_grant));
        check(256'(if_a.op_busy));
        check(256'(if_a.op_yWriteEnable));
        check(256'(if_a.op_yWriteAddress));
        check(256'(if_a.op_yReadAddress2));
        check(if_a.op_writeData);
        tick();
        reset = 1'b0;
        sb_push("arst_held_grant", 256'h0);
        check(256'(if_a.op_grant));
        sb_push("post_rst_grant", 256'h2);
        tick();
        check(256'(if_a.op_grant));

        clear_inputs();
        tick();
        tick();

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_leftover: observed %0d entries required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
